// File: rtl/m_sync_lock_ctrl_pkg.sv
// ============================================================================
//  Module   : m_sync_lock_ctrl_pkg
//  Brief    : Shared state encoding and period defaults for the sync-lock path
//  Revision : 1.0
// ============================================================================
`default_nettype none

package m_sync_lock_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_VERIFY = 2'd2,
        ST_LOCKED = 2'd3
    } state_e;

    localparam int c_def_width      = 32;
    localparam int c_def_period_min = 20;
    localparam int c_def_period_max = 10_000_000;

    // Width that holds 0..max_val without ever collapsing to zero bits.
    function automatic int f_ctr_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/m_sync_lock_ctrl_win.sv
// ============================================================================
//  Module   : m_sync_win_timer
//  Brief    : Measurement window counter with start pulse and end-of-window
//  Revision : 1.0
// ============================================================================
`default_nettype none

module m_sync_win_timer #(
    parameter int WIN_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    input  logic i_active_nxt,
    output logic o_win_start,
    output logic o_eow
);

    localparam int c_wcnt_w = $clog2(WIN_CYCLES);
    localparam logic [c_wcnt_w-1:0] c_last = c_wcnt_w'(WIN_CYCLES - 1);
    localparam logic [c_wcnt_w-1:0] c_one  = c_wcnt_w'(1);

    logic [c_wcnt_w-1:0] r_wcnt;
    logic [c_wcnt_w-1:0] w_wcnt_nxt;
    logic                r_win_start;

    always_comb begin
        w_wcnt_nxt = r_wcnt + c_one;
        if (!i_run || (r_wcnt == c_last)) begin
            w_wcnt_nxt = '0;
        end
    end

    // The start pulse is registered against the next count so it coincides
    // with the first cycle of every window, including the one entering ACQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcnt      <= '0;
            r_win_start <= 1'b0;
        end else begin
            r_wcnt      <= w_wcnt_nxt;
            r_win_start <= i_active_nxt && (w_wcnt_nxt == '0);
        end
    end

    assign o_eow       = i_run && (r_wcnt == c_last);
    assign o_win_start = r_win_start;

endmodule

`default_nettype wire

// File: rtl/m_sync_lock_ctrl.sv
// ============================================================================
//  Module   : m_sync_lock_ctrl
//  Brief    : Qualifies windowed period measurements and drives the sync-clock
//             generator once the period is stable
//  Revision : 1.0
// ============================================================================
`default_nettype none

module m_sync_lock_ctrl
    import m_sync_lock_ctrl_pkg::*;
#(
    parameter int WIDTH       = c_def_width,
    parameter int WIN_CYCLES  = 2_000_000,
    parameter int TOL         = 4,
    parameter int LOCK_CNT    = 3,
    parameter int LOSS_CNT    = 2,
    parameter int TIMEOUT_WIN = 8,
    parameter int PERIOD_MIN  = c_def_period_min,
    parameter int PERIOD_MAX  = c_def_period_max
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             meas_valid,
    input  logic [WIDTH-1:0] meas_period,
    output logic             win_start,
    output logic             gen_en,
    output logic [WIDTH-1:0] gen_period,
    output logic             locked,
    output logic             lock_err,
    output logic [1:0]       state
);

    localparam int c_mcnt_w = f_ctr_w(LOCK_CNT);
    localparam int c_miss_w = f_ctr_w(LOSS_CNT);
    localparam int c_tcnt_w = f_ctr_w(TIMEOUT_WIN);

    localparam logic [c_mcnt_w-1:0] c_mcnt_one = c_mcnt_w'(1);
    localparam logic [c_mcnt_w-1:0] c_lock_cnt = c_mcnt_w'(LOCK_CNT);
    localparam logic [c_miss_w-1:0] c_miss_one = c_miss_w'(1);
    localparam logic [c_miss_w-1:0] c_loss_cnt = c_miss_w'(LOSS_CNT);
    localparam logic [c_tcnt_w-1:0] c_tcnt_one = c_tcnt_w'(1);
    localparam logic [c_tcnt_w-1:0] c_timeout  = c_tcnt_w'(TIMEOUT_WIN);

    state_e              r_state,      w_state_nxt;
    logic [WIDTH-1:0]    r_cand,       w_cand_nxt;
    logic [WIDTH-1:0]    r_gen_period, w_gen_period_nxt;
    logic [c_mcnt_w-1:0] r_mcnt,       w_mcnt_nxt;
    logic [c_miss_w-1:0] r_miss,       w_miss_nxt;
    logic [c_tcnt_w-1:0] r_tcnt,       w_tcnt_nxt;
    logic                r_gen_en,     w_gen_en_nxt;
    logic                r_lock_err,   w_lock_err_nxt;
    logic                r_locked;

    logic [WIDTH-1:0]    r_sample;
    logic                r_have;

    logic                w_run;
    logic                w_active_nxt;
    logic                w_eow;
    logic                w_win_start;
    logic                w_in_range;
    logic                w_accept;
    logic                w_have;
    logic [WIDTH-1:0]    w_smp;
    logic signed [WIDTH:0] w_diff;
    logic [WIDTH:0]      w_abs_diff;
    logic                w_match;
    logic                w_count_win;
    logic [c_mcnt_w-1:0] w_mcnt_inc;
    logic [c_miss_w-1:0] w_miss_inc;
    logic [c_tcnt_w-1:0] w_tcnt_inc;

    assign w_run        = en && (r_state != ST_IDLE);
    assign w_active_nxt = (w_state_nxt != ST_IDLE);

    m_sync_win_timer #(
        .WIN_CYCLES (WIN_CYCLES)
    ) u_win_timer (
        .clk          (clk),
        .rst          (rst),
        .i_run        (w_run),
        .i_active_nxt (w_active_nxt),
        .o_win_start  (w_win_start),
        .o_eow        (w_eow)
    );

    assign w_in_range = (meas_period >= WIDTH'(PERIOD_MIN)) &&
                        (meas_period <= WIDTH'(PERIOD_MAX));
    assign w_accept   = w_run && meas_valid && w_in_range && !r_have;

    // A strobe landing on the EOW cycle still belongs to the ending window.
    assign w_have = r_have || w_accept;
    assign w_smp  = r_have ? r_sample : meas_period;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_have   <= 1'b0;
            r_sample <= '0;
        end else if (!w_run || w_eow) begin
            r_have   <= 1'b0;
        end else if (w_accept) begin
            r_have   <= 1'b1;
            r_sample <= meas_period;
        end
    end

    // One extra bit keeps the difference exact for any pair of WIDTH values.
    assign w_diff     = $signed({1'b0, w_smp}) - $signed({1'b0, r_cand});
    assign w_abs_diff = w_diff[WIDTH] ? (WIDTH+1)'(-w_diff) : (WIDTH+1)'(w_diff);
    assign w_match    = (w_abs_diff <= (WIDTH+1)'(TOL));

    assign w_mcnt_inc = r_mcnt + c_mcnt_one;
    assign w_miss_inc = r_miss + c_miss_one;
    assign w_tcnt_inc = r_tcnt + c_tcnt_one;

    always_comb begin
        w_state_nxt      = r_state;
        w_cand_nxt       = r_cand;
        w_gen_period_nxt = r_gen_period;
        w_mcnt_nxt       = r_mcnt;
        w_miss_nxt       = r_miss;
        w_tcnt_nxt       = r_tcnt;
        w_gen_en_nxt     = r_gen_en;
        w_lock_err_nxt   = r_lock_err;
        w_count_win      = 1'b0;

        if (!en) begin
            w_state_nxt      = ST_IDLE;
            w_cand_nxt       = '0;
            w_gen_period_nxt = '0;
            w_mcnt_nxt       = '0;
            w_miss_nxt       = '0;
            w_tcnt_nxt       = '0;
            w_gen_en_nxt     = 1'b0;
            w_lock_err_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt      = ST_ACQ;
                    w_cand_nxt       = '0;
                    w_gen_period_nxt = '0;
                    w_mcnt_nxt       = '0;
                    w_miss_nxt       = '0;
                    w_tcnt_nxt       = '0;
                    w_gen_en_nxt     = 1'b0;
                end
                ST_ACQ: begin
                    if (w_eow) begin
                        w_count_win = 1'b1;
                        if (w_have) begin
                            w_cand_nxt  = w_smp;
                            w_mcnt_nxt  = c_mcnt_one;
                            w_state_nxt = ST_VERIFY;
                        end
                    end
                end
                ST_VERIFY: begin
                    if (w_eow) begin
                        if (!w_have) begin
                            w_state_nxt = ST_ACQ;
                            w_count_win = 1'b1;
                        end else if (w_match) begin
                            if (w_mcnt_inc == c_lock_cnt) begin
                                w_state_nxt      = ST_LOCKED;
                                w_gen_period_nxt = r_cand;
                                w_gen_en_nxt     = 1'b1;
                                w_miss_nxt       = '0;
                                w_tcnt_nxt       = '0;
                            end else begin
                                w_mcnt_nxt  = w_mcnt_inc;
                                w_count_win = 1'b1;
                            end
                        end else begin
                            w_cand_nxt  = w_smp;
                            w_mcnt_nxt  = c_mcnt_one;
                            w_count_win = 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_eow) begin
                        if (w_have && w_match) begin
                            w_miss_nxt = '0;
                        end else if (w_miss_inc == c_loss_cnt) begin
                            w_state_nxt  = ST_ACQ;
                            w_gen_en_nxt = 1'b0;
                            w_miss_nxt   = '0;
                        end else begin
                            w_miss_nxt = w_miss_inc;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase

            // The fault is sticky but acquisition carries on regardless.
            if (w_count_win) begin
                if (w_tcnt_inc == c_timeout) begin
                    w_lock_err_nxt = 1'b1;
                    w_tcnt_nxt     = '0;
                end else begin
                    w_tcnt_nxt = w_tcnt_inc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cand       <= '0;
            r_gen_period <= '0;
            r_mcnt       <= '0;
            r_miss       <= '0;
            r_tcnt       <= '0;
            r_gen_en     <= 1'b0;
            r_lock_err   <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cand       <= w_cand_nxt;
            r_gen_period <= w_gen_period_nxt;
            r_mcnt       <= w_mcnt_nxt;
            r_miss       <= w_miss_nxt;
            r_tcnt       <= w_tcnt_nxt;
            r_gen_en     <= w_gen_en_nxt;
            r_lock_err   <= w_lock_err_nxt;
            r_locked     <= (w_state_nxt == ST_LOCKED);
        end
    end

    assign win_start  = w_win_start;
    assign gen_en     = r_gen_en;
    assign gen_period = r_gen_period;
    assign locked     = r_locked;
    assign lock_err   = r_lock_err;
    assign state      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_m_sync_lock_ctrl.sv
// ============================================================================
//  Module   : tb_m_sync_lock_ctrl
//  Brief    : Self-checking bench for m_sync_lock_ctrl against a window model
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_m_sync_lock_ctrl;

    localparam int WIDTH = 32;
    localparam int WIN   = 100;
    localparam int TOL   = 2;
    localparam int LOCK  = 3;
    localparam int LOSS  = 2;
    localparam int TOUT  = 6;
    localparam int PMIN  = 20;
    localparam int PMAX  = 10_000_000;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             meas_valid;
    logic [WIDTH-1:0] meas_period;
    logic             win_start;
    logic             gen_en;
    logic [WIDTH-1:0] gen_period;
    logic             locked;
    logic             lock_err;
    logic [1:0]       state;

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    m_sync_lock_ctrl #(
        .WIDTH       (WIDTH),
        .WIN_CYCLES  (WIN),
        .TOL         (TOL),
        .LOCK_CNT    (LOCK),
        .LOSS_CNT    (LOSS),
        .TIMEOUT_WIN (TOUT),
        .PERIOD_MIN  (PMIN),
        .PERIOD_MAX  (PMAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .meas_valid  (meas_valid),
        .meas_period (meas_period),
        .win_start   (win_start),
        .gen_en      (gen_en),
        .gen_period  (gen_period),
        .locked      (locked),
        .lock_err    (lock_err),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model (window level) ----------------
    // mode: 0 idle, 1 searching, 2 confirming, 3 locked
    int     m_mode = 0, m_pos = 0, m_mcnt = 0, m_miss = 0, m_tcnt = 0;
    bit     m_have = 0, m_gen = 0, m_err = 0, m_ws = 0;
    longint m_smp = 0, m_cand = 0, m_gp = 0;

    task tick_timeout();
        m_tcnt++;
        if (m_tcnt >= TOUT) begin
            m_err  = 1;
            m_tcnt = 0;
        end
    endtask

    task model_eow();
        longint d;
        bit     close;
        d     = (m_smp > m_cand) ? (m_smp - m_cand) : (m_cand - m_smp);
        close = m_have && (d <= TOL);
        case (m_mode)
            1: begin
                if (m_have) begin
                    m_cand = m_smp;
                    m_mcnt = 1;
                    m_mode = 2;
                end
                tick_timeout();
            end
            2: begin
                if (!m_have)   m_mode = 1;
                else if (close) m_mcnt++;
                else begin
                    m_cand = m_smp;
                    m_mcnt = 1;
                end
                if (m_mcnt >= LOCK) begin
                    m_mode = 3;
                    m_gp   = m_cand;
                    m_gen  = 1;
                    m_miss = 0;
                    m_tcnt = 0;
                end else begin
                    tick_timeout();
                end
            end
            3: begin
                if (close) m_miss = 0;
                else begin
                    m_miss++;
                    if (m_miss >= LOSS) begin
                        m_mode = 1;
                        m_gen  = 0;
                        m_miss = 0;
                    end
                end
            end
            default: ;
        endcase
    endtask

    always @(posedge clk) begin
        if (rst || !en) begin
            m_mode = 0; m_pos = 0; m_have = 0; m_cand = 0; m_mcnt = 0;
            m_miss = 0; m_tcnt = 0; m_gen = 0; m_gp = 0; m_err = 0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_pos = 0; m_have = 0; m_cand = 0; m_mcnt = 0;
            m_miss = 0; m_tcnt = 0; m_gen = 0; m_gp = 0;
        end else begin
            if (meas_valid && !m_have && meas_period >= PMIN && meas_period <= PMAX) begin
                m_have = 1;
                m_smp  = meas_period;
            end
            if (m_pos == WIN - 1) begin
                model_eow();
                m_pos  = 0;
                m_have = 0;
            end else begin
                m_pos++;
            end
        end
        m_ws = (m_mode != 0) && (m_pos == 0);
    end

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("model.state",      state,      m_mode);
            cmp("model.win_start",  win_start,  m_ws);
            cmp("model.gen_en",     gen_en,     m_gen);
            cmp("model.gen_period", gen_period, m_gp);
            cmp("model.locked",     locked,     (m_mode == 3));
            cmp("model.lock_err",   lock_err,   m_err);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at the negedge of window position 0; returns at the next one.
    task automatic win3(input int p0, input int o0, input int p1, input int o1,
                        input int p2, input int o2);
        for (int i = 0; i < WIN; i++) begin
            meas_valid  = 1'b0;
            meas_period = $urandom;
            if (p0 >= 0 && i == o0) begin meas_valid = 1'b1; meas_period = WIDTH'(p0); end
            if (p1 >= 0 && i == o1) begin meas_valid = 1'b1; meas_period = WIDTH'(p1); end
            if (p2 >= 0 && i == o2) begin meas_valid = 1'b1; meas_period = WIDTH'(p2); end
            @(negedge clk);
        end
        meas_valid = 1'b0;
    endtask

    task automatic win(input int p);
        win3(p, 10, -1, 0, -1, 0);
    endtask

    task automatic chk_outs(input string nm, input int st, input bit ws, input bit ge,
                            input int gp, input bit lk, input bit le);
        cmp({nm, ".state"},      state,      st);
        cmp({nm, ".win_start"},  win_start,  ws);
        cmp({nm, ".gen_en"},     gen_en,     ge);
        cmp({nm, ".gen_period"}, gen_period, gp);
        cmp({nm, ".locked"},     locked,     lk);
        cmp({nm, ".lock_err"},   lock_err,   le);
    endtask

    task automatic en_drop(input string nm);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_outs(nm, 0, 0, 0, 0, 0, 0);
        end
        en = 1'b1;
        @(negedge clk);
        chk_outs({nm, ".reentry"}, 1, 1, 0, 0, 0, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        en          = 1'b0;
        meas_valid  = 1'b0;
        meas_period = '0;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        chk_outs("reset", 0, 0, 0, 0, 0, 0);

        rst = 1'b0;
        en  = 1'b1;
        @(negedge clk);
        chk_outs("acq_entry", 1, 1, 0, 0, 0, 0);

        // clean lock
        win(50);  chk_outs("clean_w0", 2, 1, 0, 0, 0, 0);
        win(51);  chk_outs("clean_w1", 2, 1, 0, 0, 0, 0);
        win(49);  chk_outs("clean_lock", 3, 1, 1, 50, 1, 0);

        // loss of lock
        win(70);  chk_outs("loss_bad1", 3, 1, 1, 50, 1, 0);
        win(50);  chk_outs("loss_recover", 3, 1, 1, 50, 1, 0);
        win(70);
        win(-1);  chk_outs("loss_drop", 1, 1, 0, 50, 0, 0);

        // jitter reject
        win(50);
        win(60);
        win(61);  chk_outs("jitter_pre", 2, 1, 0, 50, 0, 0);
        win(62);  chk_outs("jitter_lock", 3, 1, 1, 60, 1, 0);

        en_drop("en_drop_locked");

        // filtering and EOW-cycle strobe
        win3(5, 5, 50, 10, 80, 20);   chk_outs("filter_w0", 2, 1, 0, 0, 0, 0);
        win3(51, WIN - 1, -1, 0, -1, 0); chk_outs("eow_strobe", 2, 1, 0, 0, 0, 0);
        win(49);                       chk_outs("filter_lock", 3, 1, 1, 50, 1, 0);

        // timeout
        en_drop("en_drop_tout");
        repeat (5) win(-1);
        chk_outs("tout_pre", 1, 1, 0, 0, 0, 0);
        win(-1);  chk_outs("tout_hit", 1, 1, 0, 0, 0, 1);
        repeat (3) win(50);
        chk_outs("tout_sticky", 3, 1, 1, 50, 1, 1);
        en_drop("en_clear_err");

        // reset mid-VERIFY
        win(50);  chk_outs("pre_rst", 2, 1, 0, 0, 0, 0);
        repeat (37) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_outs("rst_mid", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        chk_outs("after_rst", 1, 1, 0, 0, 0, 0);

        // randomized windows against the model
        begin
            int base;
            base = 1000;
            for (int w = 0; w < 150; w++) begin
                int r, p0, o0, p1, o1, p2, o2, sel;
                r = $urandom_range(0, 99);
                if (r < 3) begin
                    en = 1'b0; @(negedge clk); en = 1'b1; @(negedge clk);
                end else if (r < 5) begin
                    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
                end
                if ($urandom_range(0, 9) == 0) base = $urandom_range(25, 100000);
                p0 = -1; p1 = -1; p2 = -1;
                r  = $urandom_range(0, 99);
                if (r >= 30)      p0 = base + $urandom_range(0, 6) - 3;
                else if (r >= 15) p0 = base + $urandom_range(5, 200);
                o0 = $urandom_range(0, WIN - 1);
                o1 = $urandom_range(0, WIN - 1);
                o2 = $urandom_range(0, WIN - 1);
                if ($urandom_range(0, 3) == 0) begin
                    sel = $urandom_range(0, 5);
                    case (sel)
                        0: p1 = $urandom_range(0, PMIN - 2);
                        1: p1 = PMIN - 1;
                        2: p1 = PMIN;
                        3: p1 = PMAX;
                        4: p1 = PMAX + 1;
                        default: p1 = PMAX + $urandom_range(2, 1000);
                    endcase
                end
                if ($urandom_range(0, 3) == 0) p2 = base + $urandom_range(0, 50);
                win3(p0, o0, p1, o1, p2, o2);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
